// File: rtl/hazard_fwd_ctl.sv
// Hazard unit for the 5-stage MIPS pipeline: EX-stage forwarding selects, multi-cycle
// load-use stall and multi-cycle branch flush. Define HAZARD_STATS_EN for stall/flush counters.
module hazard_fwd_ctl #(
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned DM_LAT      = 1,
  parameter int unsigned FLUSH_CYC   = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk_87,
  input  logic                   rst_87,
  input  logic [RADDR_WIDTH-1:0] r1_id_in_87,
  input  logic [RADDR_WIDTH-1:0] r2_id_in_87,
  input  logic [RADDR_WIDTH-1:0] rs_id_ex_87,
  input  logic [RADDR_WIDTH-1:0] rt_id_ex_87,
  input  logic [RADDR_WIDTH-1:0] rd_id_ex_87,
  input  logic                   memrd_id_ex_87,
  input  logic                   regwr_id_ex_87,
  input  logic [RADDR_WIDTH-1:0] rd_ex_dm_87,
  input  logic                   regwr_ex_dm_87,
  input  logic [RADDR_WIDTH-1:0] rd_dm_wb_87,
  input  logic                   regwr_dm_wb_87,
  input  logic                   branch_taken_87,
  output logic [1:0]             fwd_a_87,
  output logic [1:0]             fwd_b_87,
  output logic                   stall_87,
  output logic                   flush_87,
  output logic [CNT_WIDTH-1:0]   stall_cnt_87,
  output logic [CNT_WIDTH-1:0]   flush_cnt_87
);

  localparam int unsigned MAX_LAT = (DM_LAT > FLUSH_CYC) ? DM_LAT : FLUSH_CYC;
  localparam int unsigned CW      = $clog2(MAX_LAT) + 1;
  // Entry cycle is already cycle 1, so the counter starts at length-2.
  localparam logic [CW-1:0] STALL_INIT = CW'((DM_LAT > 1) ? DM_LAT - 2 : 0);
  localparam logic [CW-1:0] FLUSH_INIT = CW'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stall_c, flush_c;
  logic            lu_hit;

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RADDR_WIDTH-1:0] src,
    input logic                   wr_mem,
    input logic [RADDR_WIDTH-1:0] rd_mem,
    input logic                   wr_wb,
    input logic [RADDR_WIDTH-1:0] rd_wb
  );
    if (wr_mem && (rd_mem != '0) && (rd_mem == src)) return 2'b10;
    else if (wr_wb && (rd_wb != '0) && (rd_wb == src)) return 2'b01;
    else return 2'b00;
  endfunction

  assign lu_hit = memrd_id_ex_87 & regwr_id_ex_87 & (rd_id_ex_87 != '0) &
                  ((rd_id_ex_87 == r1_id_in_87) | (rd_id_ex_87 == r2_id_in_87));

  always_ff @(posedge clk_87 or negedge rst_87) begin
    if (!rst_87) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus Mealy stall/flush; a taken branch preempts any stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    flush_c = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_STALL: begin
        if (branch_taken_87) begin
          flush_c = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_INIT;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (state_q == ST_STALL) begin
          stall_c = 1'b1;
          if (cnt_q == '0) state_d = ST_IDLE;
          else cnt_d = cnt_q - CW'(1);
        end else if (lu_hit) begin
          stall_c = 1'b1;
          if (DM_LAT > 1) begin
            state_d = ST_STALL;
            cnt_d   = STALL_INIT;
          end
        end
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign stall_87 = rst_87 & stall_c;
  assign flush_87 = rst_87 & flush_c;
  assign fwd_a_87 = rst_87 ? fwd_sel(rs_id_ex_87, regwr_ex_dm_87, rd_ex_dm_87,
                                     regwr_dm_wb_87, rd_dm_wb_87) : 2'b00;
  assign fwd_b_87 = rst_87 ? fwd_sel(rt_id_ex_87, regwr_ex_dm_87, rd_ex_dm_87,
                                     regwr_dm_wb_87, rd_dm_wb_87) : 2'b00;

`ifdef HAZARD_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk_87 or negedge rst_87) begin
    if (!rst_87) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_87 && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (flush_87 && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_87 = stall_cnt_q;
  assign flush_cnt_87 = flush_cnt_q;
`else
  assign stall_cnt_87 = '0;
  assign flush_cnt_87 = '0;
`endif

endmodule
